door_ctrl_timed: RTL and testbench

Parametrised automatic-door controller, the successor of the fixed 4-bit door FSM. It drives the open (ma) and close (mc) motor enables from four inputs: presence request, emergency stop, open limit and closed limit. Over the fixed FSM it adds input synchronisation, a hold-open timer, obstruction reversal with a reversal limit, a motor-run timeout and a sticky fault state with explicit clear. It sits directly under the Tiny Tapeout top, with ui_in/uo_out mapped onto its ports.

---
 rtl/door_pkg.sv | 33 +++
 rtl/sync2.sv | 40 ++++
 rtl/door_ctrl_timed.sv | 238 +++++++++++++++++++++++
 tb/tb_door_ctrl_timed.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// -----------------------------------------------------------------------------
// door_pkg
//   Shared definitions for the timed automatic-door controller:
//   - door_state_t : FSM state enum with its fixed binary encodings
//   - STATE_W      : width of the state encoding (3)
//   - REV_W        : width of the consecutive-reversal counter (2)
//   - IDX_*        : bit positions of the four asynchronous inputs inside the
//                    synchronised input vector {sen, se, la, lc}
// -----------------------------------------------------------------------------
package door_pkg;

  localparam int STATE_W = 3;
  localparam int REV_W   = 2;

  // The encodings are visible on the state output, so they are pinned here.
  // Codes 6 and 7 are unused and are steered to ST_FAULT by the FSM.
  typedef enum logic [STATE_W-1:0] {
    ST_CLOSED    = 3'd0,
    ST_OPENING   = 3'd1,
    ST_OPEN_HOLD = 3'd2,
    ST_CLOSING   = 3'd3,
    ST_STOPPED   = 3'd4,
    ST_FAULT     = 3'd5
  } door_state_t;

  // Bit positions within the synchronised input vector.
  localparam int IDX_LC  = 0;
  localparam int IDX_LA  = 1;
  localparam int IDX_SE  = 2;
  localparam int IDX_SEN = 3;
  localparam int SYNC_W  = 4;

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Parametrised-width two-flop synchroniser. Each bit is an independent
//   metastability filter; bits are not sampled coherently with each other.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (clears both flop stages)
//   ena    in   clock enable; 0 freezes both stages
//   d      in   [WIDTH] asynchronous inputs
//   q      out  [WIDTH] synchronised outputs, two enabled edges behind d
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else if (ena) begin
        meta_reg <= d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign q[gi] = sync_reg;
  end

endmodule

// File: rtl/door_ctrl_timed.sv
// -----------------------------------------------------------------------------
// door_ctrl_timed
//   Automatic-door controller with input synchronisation, hold-open timer,
//   obstruction reversal with a reversal limit, motor-run timeout and a sticky
//   fault state that needs an explicit clear.
//
// Parameters:
//   HOLD_CYCLES    cycles the door stays open after the last presence (>= 1)
//   MOTOR_TIMEOUT  max cycles in OPENING/CLOSING before FAULT (>= 2)
//   MAX_REV        consecutive closing reversals allowed before FAULT (1..4)
//   TIMER_W        timer width, must hold HOLD_CYCLES-1 and MOTOR_TIMEOUT-1
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; 0 freezes state, timer, counter, sync flops
//   sen        in   presence sensor (async)
//   se         in   emergency stop (async, level)
//   la         in   open-limit switch (async)
//   lc         in   closed-limit switch (async)
//   clr_fault  in   fault clear (synchronous, level)
//   ma         out  open-motor enable, high only in OPENING
//   mc         out  close-motor enable, high only in CLOSING
//   fault      out  high only in FAULT
//   state      out  [3] current state encoding
//   rev_cnt    out  [2] consecutive reversals in the current close attempt
// -----------------------------------------------------------------------------
module door_ctrl_timed
  import door_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1000,
  parameter int MOTOR_TIMEOUT = 4000,
  parameter int MAX_REV       = 3,
  parameter int TIMER_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               sen,
  input  logic               se,
  input  logic               la,
  input  logic               lc,
  input  logic               clr_fault,
  output logic               ma,
  output logic               mc,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [REV_W-1:0]   rev_cnt
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (MAX_REV < 1 || MAX_REV > (1 << REV_W)) begin : g_bad_max_rev
    $error("door_ctrl_timed: MAX_REV=%0d must be in 1..%0d", MAX_REV, 1 << REV_W);
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("door_ctrl_timed: HOLD_CYCLES=%0d must be >= 1", HOLD_CYCLES);
  end
  if (MOTOR_TIMEOUT < 2) begin : g_bad_timeout
    $error("door_ctrl_timed: MOTOR_TIMEOUT=%0d must be >= 2", MOTOR_TIMEOUT);
  end
  if (((HOLD_CYCLES - 1) >> TIMER_W) != 0 || ((MOTOR_TIMEOUT - 1) >> TIMER_W) != 0)
  begin : g_bad_timer_w
    $error("door_ctrl_timed: TIMER_W=%0d too narrow", TIMER_W);
  end

  // Values the timer is loaded with / compared against.
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RUN_LAST  = TIMER_W'(MOTOR_TIMEOUT - 1);
  localparam logic [REV_W-1:0]   REV_LAST  = REV_W'(MAX_REV - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic [SYNC_W-1:0] raw_in;
  logic [SYNC_W-1:0] sync_in;

  assign raw_in[IDX_SEN] = sen;
  assign raw_in[IDX_SE]  = se;
  assign raw_in[IDX_LA]  = la;
  assign raw_in[IDX_LC]  = lc;

  sync2 #(
    .WIDTH (SYNC_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .d     (raw_in),
    .q     (sync_in)
  );

  logic sen_s;
  logic se_s;
  logic la_s;
  logic lc_s;
  logic both_limits;

  assign sen_s       = sync_in[IDX_SEN];
  assign se_s        = sync_in[IDX_SE];
  assign la_s        = sync_in[IDX_LA];
  assign lc_s        = sync_in[IDX_LC];
  // Both limit switches at once means a broken switch or wiring fault.
  assign both_limits = la_s & lc_s;

  // ---------------------------------------------------------------------------
  // State, timer and reversal counter registers
  // ---------------------------------------------------------------------------
  door_state_t        state_reg;
  door_state_t        state_next;
  logic [TIMER_W-1:0] timer_reg;
  logic [TIMER_W-1:0] timer_next;
  logic [REV_W-1:0]   rev_reg;
  logic [REV_W-1:0]   rev_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLOSED;
      timer_reg <= '0;
      rev_reg   <= '0;
    end else if (ena) begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      rev_reg   <= rev_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  //   The timer has two roles: it counts up from 0 while a motor runs
  //   (timeout detection) and counts down from HOLD_LOAD in OPEN_HOLD.
  //   In-state updates are made in the case statement; loads that belong to
  //   entering a state are applied afterwards, whenever the state changes.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    rev_next   = rev_reg;

    if (state_reg != ST_FAULT && both_limits) begin
      state_next = ST_FAULT;
    end else if (state_reg != ST_FAULT && se_s) begin
      state_next = ST_STOPPED;
    end else begin
      case (state_reg)
        ST_CLOSED: begin
          if (sen_s) begin
            state_next = ST_OPENING;
          end
        end

        ST_OPENING: begin
          if (la_s) begin
            state_next = ST_OPEN_HOLD;
          end else if (timer_reg == RUN_LAST) begin
            state_next = ST_FAULT;
          end else begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end

        ST_OPEN_HOLD: begin
          // la is deliberately not checked: a door pushed off its open limit
          // still waits out the hold time.
          if (sen_s) begin
            timer_next = HOLD_LOAD;
          end else if (timer_reg == '0) begin
            state_next = ST_CLOSING;
          end else begin
            timer_next = timer_reg - TIMER_W'(1);
          end
        end

        ST_CLOSING: begin
          // Reaching the closed limit outranks a late obstruction report.
          if (lc_s) begin
            state_next = ST_CLOSED;
          end else if (sen_s) begin
            if (rev_reg < REV_LAST) begin
              state_next = ST_OPENING;
              rev_next   = rev_reg + REV_W'(1);
            end else begin
              state_next = ST_FAULT;
            end
          end else if (timer_reg == RUN_LAST) begin
            state_next = ST_FAULT;
          end else begin
            timer_next = timer_reg + TIMER_W'(1);
          end
        end

        ST_STOPPED: begin
          // Only reached with se_s low (se_s high is caught above), so the
          // stop has been released; timer and rev_cnt have been held.
          if (!se_s) begin
            state_next = lc_s ? ST_CLOSED : ST_OPENING;
          end
        end

        ST_FAULT: begin
          // se and the limit-pair rule are not exits from FAULT; only an
          // explicit clear with a sane input picture leaves it.
          if (clr_fault && !se_s && !both_limits) begin
            state_next = lc_s ? ST_CLOSED : ST_OPEN_HOLD;
            rev_next   = '0;
          end
        end

        default: begin
          state_next = ST_FAULT;
        end
      endcase
    end

    // Entry actions.
    if (state_next != state_reg) begin
      case (state_next)
        ST_OPENING,
        ST_CLOSING:   timer_next = '0;
        ST_OPEN_HOLD: timer_next = HOLD_LOAD;
        ST_CLOSED:    rev_next   = '0;
        default:      ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore outputs: decoded from the registered state only, so an asynchronous
  // reset stops both motors without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  assign ma      = (state_reg == ST_OPENING);
  assign mc      = (state_reg == ST_CLOSING);
  assign fault   = (state_reg == ST_FAULT);
  assign state   = state_reg;
  assign rev_cnt = rev_reg;

endmodule

// File: tb/tb_door_ctrl_timed.sv
// -----------------------------------------------------------------------------
// tb_door_ctrl_timed
//   Self-checking bench for door_ctrl_timed (HOLD=8, TIMEOUT=16, MAX_REV=3).
//   A behavioural door model tracks what the outputs must be; the compare
//   process checks every cycle, and directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_door_ctrl_timed;

  localparam int HOLD = 8;
  localparam int TMO  = 16;
  localparam int MREV = 3;

  localparam int S_CLOSED    = 0;
  localparam int S_OPENING   = 1;
  localparam int S_OPEN_HOLD = 2;
  localparam int S_CLOSING   = 3;
  localparam int S_STOPPED   = 4;
  localparam int S_FAULT     = 5;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       ena       = 1'b1;
  logic       sen       = 1'b0;
  logic       se        = 1'b0;
  logic       la        = 1'b0;
  logic       lc        = 1'b0;
  logic       clr_fault = 1'b0;
  logic       ma;
  logic       mc;
  logic       fault;
  logic [2:0] state;
  logic [1:0] rev_cnt;

  int n_checks = 0;
  int n_errors = 0;

  door_ctrl_timed #(
    .HOLD_CYCLES   (HOLD),
    .MOTOR_TIMEOUT (TMO),
    .MAX_REV       (MREV),
    .TIMER_W       (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .sen       (sen),
    .se        (se),
    .la        (la),
    .lc        (lc),
    .clr_fault (clr_fault),
    .ma        (ma),
    .mc        (mc),
    .fault     (fault),
    .state     (state),
    .rev_cnt   (rev_cnt)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model.
  //   Inputs reach the decision logic two enabled edges after being sampled
  //   (m_far). m_run counts edges spent with a motor running, m_quiet counts
  //   edges in OPEN_HOLD since entry or the last presence.
  // ---------------------------------------------------------------------------
  int         m_state = S_CLOSED;
  int         m_rev   = 0;
  int         m_run   = 0;
  int         m_quiet = 0;
  logic [3:0] m_near  = 4'b0;
  logic [3:0] m_far   = 4'b0;

  task automatic model_step();
    logic p_sen, p_se, p_la, p_lc;
    int   nxt;
    {p_sen, p_se, p_la, p_lc} = m_far;
    nxt = m_state;
    if (m_state != S_FAULT && p_la && p_lc) begin
      nxt = S_FAULT;
    end else if (m_state != S_FAULT && p_se) begin
      nxt = S_STOPPED;
    end else begin
      case (m_state)
        S_CLOSED: begin
          if (p_sen) nxt = S_OPENING;
        end
        S_OPENING: begin
          if (p_la) nxt = S_OPEN_HOLD;
          else if (m_run + 1 == TMO) nxt = S_FAULT;
          else m_run++;
        end
        S_OPEN_HOLD: begin
          if (p_sen) m_quiet = 0;
          else if (m_quiet + 1 == HOLD) nxt = S_CLOSING;
          else m_quiet++;
        end
        S_CLOSING: begin
          if (p_lc) nxt = S_CLOSED;
          else if (p_sen) begin
            if (m_rev + 1 < MREV) begin
              nxt = S_OPENING;
              m_rev++;
            end else begin
              nxt = S_FAULT;
            end
          end else if (m_run + 1 == TMO) nxt = S_FAULT;
          else m_run++;
        end
        S_STOPPED: begin
          nxt = p_lc ? S_CLOSED : S_OPENING;
        end
        S_FAULT: begin
          if (clr_fault && !p_se && !(p_la && p_lc)) begin
            nxt   = p_lc ? S_CLOSED : S_OPEN_HOLD;
            m_rev = 0;
          end
        end
        default: nxt = S_FAULT;
      endcase
    end
    if (nxt != m_state) begin
      m_run   = 0;
      m_quiet = 0;
      if (nxt == S_CLOSED) m_rev = 0;
    end
    m_state = nxt;
    m_far   = m_near;
    m_near  = {sen, se, la, lc};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = S_CLOSED;
      m_rev   = 0;
      m_run   = 0;
      m_quiet = 0;
      m_near  = 4'b0;
      m_far   = 4'b0;
    end else if (ena) begin
      model_step();
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model (outputs are stable at negedge).
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (state !== 3'(m_state) || rev_cnt !== 2'(m_rev) ||
          ma !== (m_state == S_OPENING) || mc !== (m_state == S_CLOSING) ||
          fault !== (m_state == S_FAULT)) begin
        n_errors++;
        $display("FAIL cycle_compare t=%0t: got state=%0d rev=%0d ma=%0b mc=%0b fault=%0b, expected state=%0d rev=%0d",
                 $time, state, rev_cnt, ma, mc, fault, m_state, m_rev);
      end
    end
  end

  // Literal expectation on both DUT and model.
  task automatic check_lit(input string name, input int exp_st, input int exp_rev);
    n_checks++;
    if (int'(state) != exp_st || int'(rev_cnt) != exp_rev ||
        ma !== (exp_st == S_OPENING) || mc !== (exp_st == S_CLOSING) ||
        fault !== (exp_st == S_FAULT)) begin
      n_errors++;
      $display("FAIL %s: got state=%0d rev=%0d ma=%0b mc=%0b fault=%0b, expected state=%0d rev=%0d",
               name, state, rev_cnt, ma, mc, fault, exp_st, exp_rev);
    end
    n_checks++;
    if (m_state != exp_st || m_rev != exp_rev) begin
      n_errors++;
      $display("FAIL %s_model: model state=%0d rev=%0d, expected state=%0d rev=%0d",
               name, m_state, m_rev, exp_st, exp_rev);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle presence pulse; returns at the negedge after the state change.
  task automatic pulse_sen();
    sen = 1'b1;
    tick(1);
    sen = 1'b0;
    tick(2);
  endtask

  // From OPENING: reach the open limit, wait out the hold, start closing.
  task automatic open_to_closing(input int rev);
    la = 1'b1;
    tick(3);
    check_lit("otc_open_hold", S_OPEN_HOLD, rev);
    tick(8);
    check_lit("otc_closing", S_CLOSING, rev);
    la = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst_n = 1'b0;
    lc = 1'b1;
    tick(2);
    check_lit("reset", S_CLOSED, 0);
    #2 rst_n = 1'b1;
    tick(3);

    // 1. Normal cycle
    pulse_sen();
    check_lit("s1_opening", S_OPENING, 0);
    lc = 1'b0;
    tick(5);
    la = 1'b1;
    tick(3);
    check_lit("s1_open_hold", S_OPEN_HOLD, 0);
    tick(7);
    check_lit("s1_hold_last", S_OPEN_HOLD, 0);
    tick(1);
    check_lit("s1_closing", S_CLOSING, 0);
    la = 1'b0;
    lc = 1'b1;
    tick(3);
    check_lit("s1_closed", S_CLOSED, 0);

    // 2. Hold extension
    pulse_sen();
    check_lit("s2_opening", S_OPENING, 0);
    lc = 1'b0;
    la = 1'b1;
    tick(3);
    check_lit("s2_open_hold", S_OPEN_HOLD, 0);
    tick(4);
    sen = 1'b1;
    tick(1);
    sen = 1'b0;
    tick(9);
    check_lit("s2_hold_extended", S_OPEN_HOLD, 0);
    tick(1);
    check_lit("s2_closing", S_CLOSING, 0);

    // 3. Reversal limit
    la = 1'b0;
    pulse_sen();
    check_lit("s3_rev1", S_OPENING, 1);
    open_to_closing(1);
    pulse_sen();
    check_lit("s3_rev2", S_OPENING, 2);
    open_to_closing(2);
    pulse_sen();
    check_lit("s3_rev_fault", S_FAULT, 2);

    // 4. Motor timeout
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_lit("s4_clear_to_hold", S_OPEN_HOLD, 0);
    tick(8);
    check_lit("s4_closing", S_CLOSING, 0);
    lc = 1'b1;
    tick(3);
    check_lit("s4_closed", S_CLOSED, 0);
    lc = 1'b0;
    pulse_sen();
    check_lit("s4_opening", S_OPENING, 0);
    tick(15);
    check_lit("s4_opening_last", S_OPENING, 0);
    tick(1);
    check_lit("s4_timeout", S_FAULT, 0);
    lc = 1'b1;
    tick(3);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_lit("s4_clear_to_closed", S_CLOSED, 0);

    // 5. Emergency stop and limit-pair fault
    lc = 1'b0;
    pulse_sen();
    check_lit("s5_opening", S_OPENING, 0);
    open_to_closing(0);
    se = 1'b1;
    tick(3);
    check_lit("s5_stopped", S_STOPPED, 0);
    se = 1'b0;
    tick(3);
    check_lit("s5_resume_open", S_OPENING, 0);
    se = 1'b1;
    tick(3);
    check_lit("s5_stopped2", S_STOPPED, 0);
    la = 1'b1;
    lc = 1'b1;
    tick(3);
    check_lit("s5_both_limits", S_FAULT, 0);
    se = 1'b0;
    la = 1'b0;
    tick(3);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_lit("s5_cleared", S_CLOSED, 0);

    // 6. Asynchronous reset and clock enable
    lc = 1'b0;
    pulse_sen();
    check_lit("s6_opening", S_OPENING, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (ma !== 1'b0 || state !== 3'd0 || m_state != S_CLOSED) begin
      n_errors++;
      $display("FAIL s6_async_reset: got ma=%0b state=%0d model=%0d, expected ma=0 state=0",
               ma, state, m_state);
    end
    tick(1);
    #2 rst_n = 1'b1;
    lc = 1'b1;
    tick(3);
    ena = 1'b0;
    sen = 1'b1;
    tick(1);
    sen = 1'b0;
    tick(4);
    check_lit("s6_ena_frozen", S_CLOSED, 0);
    ena = 1'b1;
    pulse_sen();
    check_lit("s6_ena_resumed", S_OPENING, 0);

    // Randomised phase, checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(5) == 0) sen = ~sen;
      if (se) begin
        if ($urandom_range(3) == 0) se = 1'b0;
      end else if ($urandom_range(59) == 0) begin
        se = 1'b1;
      end
      if ($urandom_range(11) == 0) la = ~la;
      if ($urandom_range(11) == 0) lc = ~lc;
      clr_fault = ($urandom_range(7) == 0);
      ena       = ($urandom_range(9) != 0);
      if ($urandom_range(699) == 0) begin
        #2 rst_n = 1'b0;
        #5 rst_n = 1'b1;
      end
    end

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
